// File: rtl/fifo_sync_circular_if.sv
// rtl/fifo_sync_circular_if.sv - producer/consumer handshake bundle for fifo_sync_circular
interface fifo_sync_circular_if #(
  parameter int WIDTH = 8
);
  logic             write_in;
  logic [WIDTH-1:0] data_write_in;
  logic             read_in;
  logic [WIDTH-1:0] data_read_out;
  logic             full_out;
  logic             empty_out;

  modport master (
    output write_in, data_write_in, read_in,
    input  data_read_out, full_out, empty_out
  );

  modport slave (
    input  write_in, data_write_in, read_in,
    output data_read_out, full_out, empty_out
  );
endinterface

// File: rtl/fifo_sync_circular.sv
// rtl/fifo_sync_circular.sv - single-clock circular FIFO, show-ahead read, wrap-bit pointers
module fifo_sync_circular #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 nrst_in,
  fifo_sync_circular_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             wr_accept;
  logic             rd_accept;

  // MSB is the wrap bit: equal low bits with differing MSBs means one lap ahead
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_accept = bus.write_in && !full;
  assign rd_accept = bus.read_in && !empty;

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_accept) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is deliberately left unreset; empty gating hides stale contents
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[AW-1:0]] <= bus.data_write_in;
  end

  assign bus.empty_out     = empty;
  assign bus.full_out      = full;
  assign bus.data_read_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_fifo_sync_circular.sv
// tb/tb_fifo_sync_circular.sv - directed self-checking bench for fifo_sync_circular
module tb_fifo_sync_circular;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk;
  logic nrst_in;
  int   errors;
  int   checks;

  fifo_sync_circular_if #(.WIDTH(WIDTH)) bus ();

  fifo_sync_circular #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .nrst_in (nrst_in),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_data;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] fill [DEPTH];
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic e_empty, input logic e_full,
                           input logic [7:0] e_data);
    check({name, ".empty"}, {31'd0, bus.empty_out}, {31'd0, e_empty});
    check({name, ".full"},  {31'd0, bus.full_out},  {31'd0, e_full});
    check({name, ".data"},  {24'd0, bus.data_read_out}, {24'd0, e_data});
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
    bus.write_in      = wr;
    bus.data_write_in = wd;
    bus.read_in       = rd;
    @(posedge clk);
    #1;
    bus.write_in = 1'b0;
    bus.read_in  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    nrst_in = 1'b0;
    #1;
    check_out("reset_async", 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    nrst_in = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.write_in      = 1'b0;
    bus.read_in       = 1'b0;
    bus.data_write_in = '0;
    nrst_in           = 1'b0;

    // Reset visible before the first clock edge
    #2;
    check_out("reset_initial", 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    nrst_in = 1'b1;

    vecs[0] = '{"sa_write",   1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{"sa_pop",     1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{"empty_rw",   1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
    vecs[3] = '{"pop_3c",     1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{"empty_read", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{"wr_5a",      1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A};
    vecs[6] = '{"rw_one",     1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[7] = '{"pop_c3",     1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd);
      check_out(vecs[i].name, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_data);
    end

    // Fill to DEPTH, then a rejected 17th write
    fill[0] = 8'h10;
    fill[1] = 8'h01;
    fill[2] = 8'h91;
    for (int i = 3; i < DEPTH; i++) fill[i] = 8'(i * 8'h13 + 8'h07);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, fill[i], 1'b0);
      exp_q.push_back(fill[i]);
      check_out($sformatf("fill_%0d", i), 1'b0, (i == DEPTH - 1), fill[0]);
    end
    step(1'b1, 8'h55, 1'b0);
    check_out("fill_overflow", 1'b0, 1'b1, fill[0]);

    // Full boundary: read accepted, write dropped
    step(1'b1, 8'hEE, 1'b1);
    void'(exp_q.pop_front());
    check_out("full_rw", 1'b0, 1'b0, fill[1]);
    step(1'b1, 8'hEE, 1'b0);
    exp_q.push_back(8'hEE);
    check_out("refill", 1'b0, 1'b1, fill[1]);

    // Drain in order, head checked before each consuming edge
    for (int i = 0; i < DEPTH; i++) begin
      check({$sformatf("drain_%0d", i), ".data"}, {24'd0, bus.data_read_out}, {24'd0, exp_q[0]});
      step(1'b0, 8'h00, 1'b1);
      void'(exp_q.pop_front());
      check($sformatf("drain_%0d.full", i), {31'd0, bus.full_out}, 32'd0);
    end
    check_out("drained", 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_out("over_read", 1'b1, 1'b0, 8'h00);
    step(1'b1, 8'h77, 1'b0);
    check_out("post_drain_wr", 1'b0, 1'b0, 8'h77);
    step(1'b0, 8'h00, 1'b1);
    check_out("post_drain_pop", 1'b1, 1'b0, 8'h00);

    // Sustained simultaneous traffic with 5 words resident, across pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0);
      exp_q.push_back(8'(8'h20 + i));
    end
    for (int i = 0; i < 40; i++) begin
      check($sformatf("sim_%0d.head", i), {24'd0, bus.data_read_out}, {24'd0, exp_q[0]});
      step(1'b1, 8'(8'h25 + i), 1'b1);
      void'(exp_q.pop_front());
      exp_q.push_back(8'(8'h25 + i));
      check($sformatf("sim_%0d.empty", i), {31'd0, bus.empty_out}, 32'd0);
      check($sformatf("sim_%0d.full", i),  {31'd0, bus.full_out},  32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sim_tail_%0d", i), {24'd0, bus.data_read_out}, {24'd0, exp_q[0]});
      step(1'b0, 8'h00, 1'b1);
      void'(exp_q.pop_front());
    end
    check_out("sim_end", 1'b1, 1'b0, 8'h00);

    // Reset mid-operation discards stored words at once
    step(1'b1, 8'h99, 1'b0);
    step(1'b1, 8'h98, 1'b0);
    check_out("pre_reset", 1'b0, 1'b0, 8'h99);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    check_out("after_reset", 1'b1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_sync_circular.md
# fifo_sync_circular

Single-clock circular-buffer FIFO with first-word-fall-through read data. It sits between a producer and a consumer in the same clock domain and decouples them by up to DEPTH words of WIDTH bits. Full and empty flags give backpressure, and both derive from wrap-bit read/write pointers.

## Interface
- DEPTH, 16: number of storage words; must be a power of two, ≥2
- WIDTH, 8: data word width in bits
- clk  input  1  single clock; all state changes on rising edge
- nrst_in  input  1  reset, asynchronous and active-low; clears pointers immediately on assertion
- write_in  input  1  write request; sampled on rising edge of clk
- data_write_in  input  WIDTH  word to store when a write is accepted
- read_in  input  1  read (pop) request; sampled on rising edge of clk
- data_read_out  output  WIDTH  head-of-queue word (show-ahead); 0 while empty
- full_out  output  1  high when DEPTH words are stored
- empty_out  output  1  high when no words are stored

## Operation
- Storage: DEPTH×WIDTH register array; memory contents are not reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits. The low bits index memory; the MSB is a wrap bit. Pointers increment modulo 2·DEPTH.
- empty_out = (wr_ptr == rd_ptr).
- full_out = (low bits equal) and (MSBs differ).
- Write accepted iff write_in=1 and full_out=0 (pre-edge value). On acceptance: mem[wr_ptr low bits] ← data_write_in, then wr_ptr+1.
- Read accepted iff read_in=1 and empty_out=0 (pre-edge value). On acceptance: rd_ptr+1.
- Rejected requests are dropped silently; no state changes. The requester must hold data and retry.
- Simultaneous read and write are allowed. Each is evaluated independently against the pre-edge flags:
  - not full, not empty: both accepted; occupancy unchanged.
  - full: read accepted, write rejected.
  - empty: write accepted, read rejected.
- data_read_out = mem[rd_ptr low bits] when empty_out=0, else 0. The output is combinational from registered pointers and memory.
- Word order strictly preserved, including across any number of pointer wrap-arounds.

## Timing
- On nrst_in=0, asynchronously: wr_ptr=0, rd_ptr=0, empty_out=1, full_out=0, data_read_out=0.
- Reset deassertion takes effect at the next rising edge. Reset asserted mid-operation discards all stored words immediately.
- Write latency: a word written at edge k is visible on data_read_out and drops empty_out right after edge k (one-cycle write-to-read).
- Read: the current head is valid on data_read_out before the edge; it is consumed at the edge where read_in=1. The next word, or 0 if now empty, appears after that edge.
- full_out rises right after the edge that accepts the DEPTH-th outstanding word. It falls right after the first accepted read.
- Flags and data are functions of registered state only. There is no combinational path from write_in/read_in to any output.
- Sustained throughput: one write and one read per cycle.

## Test plan
- Reset: assert nrst_in=0 mid-cycle -> empty_out=1, full_out=0, data_read_out=0 immediately, without waiting for a clock edge.
- Fill: write 16 words 8'h10,8'h01,8'h91,… (DEPTH=16) -> full_out=0 after words 1–15, full_out=1 after word 16; a 17th write with 8'h55 is ignored.
- Drain: with the FIFO full, assert read_in 16 cycles -> data_read_out before each edge shows the words in written order; empty_out=1 after the 16th read; further reads leave the pointers unchanged and data_read_out=0.
- Show-ahead: from empty, write 8'hA5 at edge k -> empty_out=0 and data_read_out=8'hA5 after edge k, without any read_in.
- Simultaneous: with 5 words stored, assert write_in and read_in for 40 cycles with an incrementing pattern -> occupancy stays 5, the data sequence is intact across pointer wrap, and the flags never toggle.
- Boundary simultaneous: when full, read+write -> one word popped, write dropped, full_out=0. When empty, read+write -> word stored, empty_out=0.
